tc0110pr_bus_master: RTL and testbench
======================================

# tc0110pr_bus_master

Bus initiator that drives the TC0110PR palette chip's CPU-side port (SCEn/VA/RWn/UDSn/LDSn/Din/Dout/DACKn) for block palette transfers. It uploads a run of colour words from a write stream, or dumps a run to a read stream, without the 68000. Typical uses are savestate restore/capture and debug. It sits beside the CPU address decoder and is muxed onto the palette chip's CPU port while `busy` is high.

## Interface
- `TIMEOUT`, 64: cycles to wait for DACKn low before aborting an access.
- `clk` in 1: system clock.
- `reset_n` in 1: synchronous, active-low reset.
- `start` in 1: begin a transfer; sampled only in IDLE.
- `dir_rd` in 1: 0 = upload (write palette), 1 = dump (read palette); latched at start.
- `base_addr` in 13: first palette word address; latched at start.
- `len` in 14: word count, 0..8192; latched at start.
- `wdata` in 16: upload word.
- `wvalid` in 1: upload word available.
- `wready` out 1: one-cycle pop strobe for `wdata`.
- `rdata` out 16: dumped word.
- `rvalid` out 1: one-cycle strobe; sink cannot stall.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle completion pulse.
- `error` out 1: sticky timeout flag, cleared by the next accepted start.
- `pr_sce_n` out 1: to chip SCEn.
- `pr_va` out 2: to chip VA.
- `pr_rw_n` out 1: to chip RWn.
- `pr_uds_n` out 1: to chip UDSn.
- `pr_lds_n` out 1: to chip LDSn.
- `pr_dout` out 16: to chip Din.
- `pr_din` in 16: from chip Dout.
- `pr_dack_n` in 1: from chip DACKn.

## Operation
- All outputs are registered. Reset values: `pr_sce_n`=1, `pr_rw_n`=1, `pr_uds_n`=1, `pr_lds_n`=1, `pr_va`=0, `pr_dout`=0, `wready`=0, `rvalid`=0, `rdata`=0, `busy`=0, `done`=0, `error`=0.
- Sequencer states: IDLE → ADDR → DATA → (next word ADDR | RELEASE) → FINISH → IDLE.
- Every access runs through a bus sub-FSM:
  - ASSERT: `pr_sce_n`=0 for 1 cycle; DACKn is ignored because the chip reports stale high here.
  - WAIT: `pr_sce_n`=0 until `pr_dack_n`=0.
  - RECOVER: `pr_sce_n`=1 for exactly 1 cycle, so the chip sees a fresh falling edge on the next access.
- VA, RWn, UDSn, LDSn and `pr_dout` are set on entry to ASSERT and held through RECOVER.
- ADDR access: VA=0, RWn=0, UDSn=LDSn=0, `pr_dout`={3'b0, cur_addr}.
- DATA access, upload: VA=1, RWn=0, both strobes low, `pr_dout`=`wdata`.
  - Launched only when `wvalid`=1; otherwise stall before ASSERT with `pr_sce_n`=1.
  - `wready` pulses on the ASSERT cycle.
- DATA access, dump: VA=1, RWn=1, both strobes low.
  - On the WAIT cycle that samples `pr_dack_n`=0, capture `rdata`<=`pr_din`.
  - `rvalid` pulses the following cycle.
- After each DATA access, cur_addr increments. 13-bit wrap: 8191 → 0.
- RELEASE access: VA=2, RWn=0, both strobes low, `pr_dout`=0. This returns the chip to video mode.
- FINISH: `done`=1 for 1 cycle; `busy`=0 from the next cycle.
- `len`=0: no ADDR/DATA accesses; only the RELEASE access, then `done`.
- Timeout: if WAIT lasts TIMEOUT cycles:
  - go to RECOVER, set `error`=1, skip all remaining words and RELEASE;
  - `done` still pulses once.
- `start` while busy is ignored.
- `reset_n` low mid-transfer: all outputs return to reset values on the next edge, with no RELEASE access. The 68000 side must re-release.

## Timing
- Start accepted at edge S (cycle 0). `busy`=1 and `pr_sce_n`=0 both appear at cycle 1.
- With a zero-wait responder that drops DACKn one cycle after the SCEn fall, each access takes 3 cycles: ASSERT, WAIT (samples 0), RECOVER.
- Upload with `wvalid` held high: N words take 6N+3 access cycles; `done` is at cycle 6N+4.
- Dump: same as upload. `rvalid` for word k is at cycle 6k+6.
- Each extra responder wait cycle adds exactly 1 cycle to that access.

## Test plan
- Upload: base=0x100, len=2, wdata 0x7FFF then 0x001F, wvalid held, behavioural chip model → model RAM[0x100]=0x7FFF, RAM[0x101]=0x001F; a VA=2 write seen; `done` at cycle 16; `wready` pulses at cycles 4 and 10.
- Dump: preload RAM[0x1FFF]=0x1234, RAM[0x0000]=0xABCD, base=0x1FFF, len=2 → `rdata` 0x1234 then 0xABCD (address wrap verified); second ADDR write carries 0x0000.
- Stall: wvalid low for 5 cycles before word 1 → `pr_sce_n` stays high during the stall; `done` is delayed by exactly 5 cycles.
- Timeout: model never asserts DACKn on the first DATA access → after 64 WAIT cycles `pr_sce_n`=1, `error`=1, single `done`, no VA=2 access; the next start clears `error`.
- len=0 → only one RELEASE access; `done` at cycle 4.
- Reset at cycle 8 of a len=4 upload → the next cycle shows `pr_sce_n`=1, `busy`=0, all outputs at reset values; a new start works normally.

Source files
------------

// File: rtl/tc0110pr_bus_master.sv
// tc0110pr_bus_master
// Block-transfer initiator for the TC0110PR palette chip CPU port.
// It uploads a run of colour words from a write stream, or dumps a run to a
// read stream. Each word costs two bus accesses: an address write (VA=0)
// followed by a data access (VA=1). A final VA=2 write hands the chip back to
// video mode. Every access goes through ASSERT -> WAIT -> RECOVER so that the
// chip always sees a clean SCEn falling edge.

module tc0110pr_bus_master #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        dir_rd,
    input  logic [12:0] base_addr,
    input  logic [13:0] len,
    input  logic [15:0] wdata,
    input  logic        wvalid,
    output logic        wready,
    output logic [15:0] rdata,
    output logic        rvalid,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        pr_sce_n,
    output logic [1:0]  pr_va,
    output logic        pr_rw_n,
    output logic        pr_uds_n,
    output logic        pr_lds_n,
    output logic [15:0] pr_dout,
    input  logic [15:0] pr_din,
    input  logic        pr_dack_n
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    // Transfer-level sequencing: which kind of access is current or next.
    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_ADDR,
        SEQ_DATA,
        SEQ_RELEASE,
        SEQ_FINISH
    } seq_e;

    // Per-access bus phase. BUS_IDLE means no access is in flight (either
    // about to launch or stalled waiting for upload data).
    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_ASSERT,
        BUS_WAIT,
        BUS_RECOVER
    } bus_e;

    seq_e              seq_q, seq_d;
    bus_e              bus_q, bus_d;
    logic              dir_q, dir_d;
    logic [12:0]       addr_q, addr_d;
    logic [13:0]       remain_q, remain_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;

    logic              sce_n_q, sce_n_d;
    logic [1:0]        va_q, va_d;
    logic              rw_n_q, rw_n_d;
    logic              uds_n_q, uds_n_d;
    logic              lds_n_q, lds_n_d;
    logic [15:0]       dout_q, dout_d;
    logic              wready_q, wready_d;
    logic              rvalid_q, rvalid_d;
    logic [15:0]       rdata_q, rdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              launch_req;
    logic              upload_stall;

    // Next-state logic: sequencer and bus phase together, with the launch of
    // the following access folded into the same cycle as RECOVER's exit so
    // back-to-back accesses have no idle gap.
    always_comb begin
        seq_d      = seq_q;
        bus_d      = bus_q;
        dir_d      = dir_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        wait_cnt_d = wait_cnt_q;
        sce_n_d    = sce_n_q;
        va_d       = va_q;
        rw_n_d     = rw_n_q;
        uds_n_d    = uds_n_q;
        lds_n_d    = lds_n_q;
        dout_d     = dout_q;
        wready_d   = 1'b0;
        rvalid_d   = 1'b0;
        rdata_d    = rdata_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = error_q;
        launch_req = 1'b0;

        case (seq_q)
            SEQ_IDLE: begin
                if (start) begin
                    dir_d    = dir_rd;
                    addr_d   = base_addr;
                    remain_d = len;
                    error_d  = 1'b0;
                    bus_d    = BUS_IDLE;
                    seq_d    = (len == 14'd0) ? SEQ_RELEASE : SEQ_ADDR;
                end
            end

            SEQ_FINISH: begin
                busy_d = 1'b0;
                seq_d  = SEQ_IDLE;
            end

            default: begin
                case (bus_q)
                    BUS_IDLE: begin
                        launch_req = 1'b1;
                    end

                    BUS_ASSERT: begin
                        bus_d      = BUS_WAIT;
                        wait_cnt_d = '0;
                    end

                    BUS_WAIT: begin
                        if (!pr_dack_n) begin
                            sce_n_d = 1'b1;
                            bus_d   = BUS_RECOVER;
                            if (seq_q == SEQ_DATA && dir_q) begin
                                rdata_d  = pr_din;
                                rvalid_d = 1'b1;
                            end
                        end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                            sce_n_d = 1'b1;
                            bus_d   = BUS_RECOVER;
                            error_d = 1'b1;
                        end else begin
                            wait_cnt_d = wait_cnt_q + CNT_W'(1);
                        end
                    end

                    BUS_RECOVER: begin
                        bus_d = BUS_IDLE;
                        if (error_q || seq_q == SEQ_RELEASE) begin
                            done_d = 1'b1;
                            seq_d  = SEQ_FINISH;
                        end else if (seq_q == SEQ_ADDR) begin
                            seq_d      = SEQ_DATA;
                            launch_req = 1'b1;
                        end else begin
                            addr_d     = addr_q + 13'd1;
                            remain_d   = remain_q - 14'd1;
                            seq_d      = (remain_q == 14'd1) ? SEQ_RELEASE : SEQ_ADDR;
                            launch_req = 1'b1;
                        end
                    end

                    default: begin
                        bus_d = BUS_IDLE;
                    end
                endcase
            end
        endcase

        upload_stall = (seq_d == SEQ_DATA) && !dir_q && !wvalid;

        if (launch_req && !upload_stall) begin
            bus_d   = BUS_ASSERT;
            sce_n_d = 1'b0;
            busy_d  = 1'b1;
            uds_n_d = 1'b0;
            lds_n_d = 1'b0;
            case (seq_d)
                SEQ_ADDR: begin
                    va_d   = 2'd0;
                    rw_n_d = 1'b0;
                    dout_d = {3'b000, addr_d};
                end
                SEQ_DATA: begin
                    va_d     = 2'd1;
                    rw_n_d   = dir_q;
                    dout_d   = dir_q ? 16'h0000 : wdata;
                    wready_d = !dir_q;
                end
                default: begin
                    va_d   = 2'd2;
                    rw_n_d = 1'b0;
                    dout_d = 16'h0000;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset; a reset
    // mid-transfer simply abandons the transfer without a release access.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            seq_q      <= SEQ_IDLE;
            bus_q      <= BUS_IDLE;
            dir_q      <= 1'b0;
            addr_q     <= 13'd0;
            remain_q   <= 14'd0;
            wait_cnt_q <= '0;
            sce_n_q    <= 1'b1;
            va_q       <= 2'd0;
            rw_n_q     <= 1'b1;
            uds_n_q    <= 1'b1;
            lds_n_q    <= 1'b1;
            dout_q     <= 16'h0000;
            wready_q   <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= 16'h0000;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            seq_q      <= seq_d;
            bus_q      <= bus_d;
            dir_q      <= dir_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            wait_cnt_q <= wait_cnt_d;
            sce_n_q    <= sce_n_d;
            va_q       <= va_d;
            rw_n_q     <= rw_n_d;
            uds_n_q    <= uds_n_d;
            lds_n_q    <= lds_n_d;
            dout_q     <= dout_d;
            wready_q   <= wready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign pr_sce_n = sce_n_q;
    assign pr_va    = va_q;
    assign pr_rw_n  = rw_n_q;
    assign pr_uds_n = uds_n_q;
    assign pr_lds_n = lds_n_q;
    assign pr_dout  = dout_q;
    assign wready   = wready_q;
    assign rvalid   = rvalid_q;
    assign rdata    = rdata_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule

// File: tb/tb_tc0110pr_bus_master.sv
// tb_tc0110pr_bus_master
// Bench for the palette bus master: a behavioural TC0110PR chip model with
// programmable DACKn latency per access, a cycle-timeline reference model
// built from the access rules, and a per-cycle compare of every output.

module tb_tc0110pr_bus_master;

    localparam int MAXC = 1024;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        dir_rd = 1'b0;
    logic [12:0] base_addr = 13'd0;
    logic [13:0] len = 14'd0;
    logic [15:0] wdata = 16'h0000;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [15:0] rdata;
    logic        rvalid;
    logic        busy;
    logic        done;
    logic        error;
    logic        pr_sce_n;
    logic [1:0]  pr_va;
    logic        pr_rw_n;
    logic        pr_uds_n;
    logic        pr_lds_n;
    logic [15:0] pr_dout;
    logic [15:0] pr_din = 16'h0000;
    logic        pr_dack_n = 1'b1;

    tc0110pr_bus_master #(.TIMEOUT(64)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .dir_rd(dir_rd),
        .base_addr(base_addr), .len(len), .wdata(wdata), .wvalid(wvalid),
        .wready(wready), .rdata(rdata), .rvalid(rvalid), .busy(busy),
        .done(done), .error(error), .pr_sce_n(pr_sce_n), .pr_va(pr_va),
        .pr_rw_n(pr_rw_n), .pr_uds_n(pr_uds_n), .pr_lds_n(pr_lds_n),
        .pr_dout(pr_dout), .pr_din(pr_din), .pr_dack_n(pr_dack_n)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;
    int cur_t = 0;

    // Chip model state
    logic [15:0] ram [0:8191];
    logic [12:0] chip_addr = 13'd0;
    int          extras [0:255];
    int          acc_idx = 0;
    int          low_cnt = 0;
    int          cur_extra = 0;
    int          release_cnt = 0;
    int          addr_log [$];

    // Reference timeline
    logic        exp_sce_n [MAXC];
    logic        exp_busy [MAXC];
    logic        exp_done [MAXC];
    logic        exp_wready [MAXC];
    logic        exp_rvalid [MAXC];
    logic        exp_error [MAXC];
    logic [15:0] exp_rdata [MAXC];
    bit          exp_chk [MAXC];
    logic [1:0]  exp_va [MAXC];
    logic        exp_rw [MAXC];
    logic [15:0] exp_dout [MAXC];
    bit          gate [MAXC];
    logic [15:0] words [0:63];
    logic [15:0] rdata_hold = 16'h0000;
    int          done_t = 0;
    bit          timed_out = 0;

    // Observations
    int          wr_t [$];
    int          rv_t [$];
    int          rv_d [$];
    int          dut_done_t = -1;
    int          done_cnt = 0;

    // Chip responder: acknowledges each SCEn-low access after 1 + extra cycles
    // and performs the register/RAM action at the moment it acknowledges.
    always @(negedge clk) begin
        if (pr_sce_n) begin
            low_cnt   = 0;
            pr_dack_n = 1'b1;
        end else begin
            if (low_cnt == 0) begin
                cur_extra = (acc_idx < 256) ? extras[acc_idx] : 0;
                acc_idx++;
            end
            low_cnt++;
            if (pr_dack_n && low_cnt >= 2 + cur_extra) begin
                pr_dack_n = 1'b0;
                if (!pr_rw_n) begin
                    case (pr_va)
                        2'd0: begin chip_addr = pr_dout[12:0]; addr_log.push_back(int'(pr_dout)); end
                        2'd1: ram[chip_addr] = pr_dout;
                        2'd2: release_cnt++;
                        default: ;
                    endcase
                end else if (pr_va == 2'd1) begin
                    pr_din = ram[chip_addr];
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("[TB] FAIL %s t=%0d actual=%h required=%h", name, cur_t, act, exp);
        end
    endtask

    // Timeline model: each access occupies launch + (1+extra) wait cycles +
    // one recover cycle; an upload data access launches only at a cycle whose
    // preceding cycle had wvalid; a wait longer than 64 cycles aborts.
    task automatic build_model(input bit d, input int base, input int n);
        int c, r, e, acc, t_err, kind, wa;
        for (int t = 0; t < MAXC; t++) begin
            exp_sce_n[t] = 1'b1; exp_busy[t] = 1'b0; exp_done[t] = 1'b0;
            exp_wready[t] = 1'b0; exp_rvalid[t] = 1'b0; exp_error[t] = 1'b0;
            exp_rdata[t] = rdata_hold; exp_chk[t] = 1'b0;
        end
        c = 1; acc = 0; timed_out = 0; t_err = MAXC;
        for (int a = 0; a < 2 * n + 1 && !timed_out; a++) begin
            kind = (a == 2 * n) ? 2 : (a % 2);
            wa   = (base + a / 2) % 8192;
            if (kind == 1 && !d)
                while (c < MAXC - 80 && !gate[c - 1]) c++;
            exp_chk[c] = 1'b1;
            exp_va[c]  = 2'(kind);
            exp_rw[c]  = (kind == 1) && d;
            if (kind == 0)      exp_dout[c] = 16'(wa);
            else if (kind == 1) exp_dout[c] = d ? 16'h0000 : words[a / 2];
            else                exp_dout[c] = 16'h0000;
            if (kind == 1 && !d) exp_wready[c] = 1'b1;
            e = extras[acc];
            acc++;
            if (e <= 63) r = c + 2 + e;
            else begin r = c + 65; timed_out = 1; t_err = r; end
            for (int t = c; t < r; t++) exp_sce_n[t] = 1'b0;
            if (kind == 1 && d && !timed_out) begin
                exp_rvalid[r] = 1'b1;
                for (int t = r; t < MAXC; t++) exp_rdata[t] = ram[wa];
                rdata_hold = ram[wa];
            end
            c = r + 1;
        end
        done_t = c;
        exp_done[c] = 1'b1;
        for (int t = 1; t <= c; t++) exp_busy[t] = 1'b1;
        for (int t = t_err; t < MAXC; t++) exp_error[t] = 1'b1;
    endtask

    task automatic check_cycle(input int t);
        checkOutput("busy",   busy,     exp_busy[t]);
        checkOutput("sce_n",  pr_sce_n, exp_sce_n[t]);
        checkOutput("done",   done,     exp_done[t]);
        checkOutput("wready", wready,   exp_wready[t]);
        checkOutput("rvalid", rvalid,   exp_rvalid[t]);
        checkOutput("error",  error,    exp_error[t]);
        checkOutput("rdata",  rdata,    exp_rdata[t]);
        if (exp_chk[t]) begin
            checkOutput("va",    pr_va,    exp_va[t]);
            checkOutput("rw_n",  pr_rw_n,  exp_rw[t]);
            checkOutput("dout",  pr_dout,  exp_dout[t]);
            checkOutput("uds_n", pr_uds_n, 1'b0);
            checkOutput("lds_n", pr_lds_n, 1'b0);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        checkOutput({tag, "_sce_n"},  pr_sce_n, 1'b1);
        checkOutput({tag, "_rw_n"},   pr_rw_n,  1'b1);
        checkOutput({tag, "_uds_n"},  pr_uds_n, 1'b1);
        checkOutput({tag, "_lds_n"},  pr_lds_n, 1'b1);
        checkOutput({tag, "_va"},     pr_va,    2'd0);
        checkOutput({tag, "_dout"},   pr_dout,  16'h0);
        checkOutput({tag, "_wready"}, wready,   1'b0);
        checkOutput({tag, "_rvalid"}, rvalid,   1'b0);
        checkOutput({tag, "_rdata"},  rdata,    16'h0);
        checkOutput({tag, "_busy"},   busy,     1'b0);
        checkOutput({tag, "_done"},   done,     1'b0);
        checkOutput({tag, "_error"},  error,    1'b0);
    endtask

    task automatic clear_env();
        for (int i = 0; i < 256; i++) extras[i] = 0;
        for (int i = 0; i < MAXC; i++) gate[i] = 1'b1;
    endtask

    // Runs one transfer, comparing every cycle from the start edge through
    // two cycles past the expected done. abort_t >= 0 drops reset_n there.
    task automatic applyStimulus(input bit d, input int base, input int n,
                                 input int abort_t, input int spur_t);
        int popped;
        build_model(d, base, n);
        wr_t.delete(); rv_t.delete(); rv_d.delete();
        dut_done_t = -1; done_cnt = 0; popped = 0;
        @(negedge clk);
        acc_idx = 0; start = 1'b1; dir_rd = d;
        base_addr = 13'(base); len = 14'(n); wvalid = 1'b0;
        @(posedge clk);
        for (int t = 0; t <= done_t + 2 && t < MAXC; t++) begin
            @(negedge clk);
            cur_t = t;
            if (t == spur_t) begin
                start = 1'b1; dir_rd = ~d;
                base_addr = 13'($urandom); len = 14'($urandom_range(1, 9));
            end else begin
                start = 1'b0;
            end
            check_cycle(t);
            if (wready) wr_t.push_back(t);
            if (rvalid) begin rv_t.push_back(t); rv_d.push_back(int'(rdata)); end
            if (done) begin done_cnt++; if (dut_done_t < 0) dut_done_t = t; end
            if (t == abort_t) begin reset_n = 1'b0; break; end
            if (wready) popped++;
            wvalid = gate[t] && (popped < n);
            wdata  = (popped < n) ? words[popped] : 16'h0000;
        end
        start = 1'b0; wvalid = 1'b0;
    endtask

    initial begin
        int rel0, n, base, d, nsent;
        for (int i = 0; i < 8192; i++) ram[i] = 16'($urandom);
        clear_env();

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        cur_t = -1;
        check_reset_vals("rst");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Upload two words, zero-wait responder
        $display("[TB] upload len=2");
        words[0] = 16'h7FFF; words[1] = 16'h001F;
        rel0 = release_cnt;
        applyStimulus(1'b0, 'h100, 2, -1, -1);
        checkOutput("up_done_cycle", dut_done_t, 16);
        checkOutput("up_model_done", done_t, 16);
        checkOutput("up_wready_n", wr_t.size(), 2);
        if (wr_t.size() == 2) begin
            checkOutput("up_wready0", wr_t[0], 4);
            checkOutput("up_wready1", wr_t[1], 10);
        end
        checkOutput("up_ram100", ram['h100], 16'h7FFF);
        checkOutput("up_ram101", ram['h101], 16'h001F);
        checkOutput("up_release", release_cnt - rel0, 1);

        // Dump across the address wrap
        $display("[TB] dump wrap");
        ram['h1FFF] = 16'h1234; ram[0] = 16'hABCD;
        addr_log.delete();
        applyStimulus(1'b1, 'h1FFF, 2, -1, -1);
        checkOutput("dump_rv_n", rv_d.size(), 2);
        if (rv_d.size() == 2) begin
            checkOutput("dump_d0", rv_d[0], 'h1234);
            checkOutput("dump_d1", rv_d[1], 'hABCD);
            checkOutput("dump_t0", rv_t[0], 6);
            checkOutput("dump_t1", rv_t[1], 12);
        end
        checkOutput("dump_addr_n", addr_log.size(), 2);
        if (addr_log.size() == 2) checkOutput("dump_addr1", addr_log[1], 0);

        // Upload stall: wvalid low for five cycles ahead of word 1
        $display("[TB] stall");
        words[0] = 16'h1111; words[1] = 16'h2222;
        for (int t = 9; t <= 13; t++) gate[t] = 1'b0;
        applyStimulus(1'b0, 'h20, 2, -1, -1);
        checkOutput("stall_done", dut_done_t, 21);
        clear_env();

        // Timeout on the first data access
        $display("[TB] timeout");
        rel0 = release_cnt;
        extras[1] = 1000;
        applyStimulus(1'b0, 'h300, 3, -1, -1);
        checkOutput("to_done", dut_done_t, 70);
        checkOutput("to_done_cnt", done_cnt, 1);
        checkOutput("to_error", error, 1'b1);
        checkOutput("to_release", release_cnt - rel0, 0);
        clear_env();

        // len = 0 also confirms the next start clears error
        $display("[TB] len0");
        rel0 = release_cnt;
        applyStimulus(1'b0, 'h50, 0, -1, -1);
        checkOutput("len0_done", dut_done_t, 4);
        checkOutput("len0_release", release_cnt - rel0, 1);

        // Ack on the very last allowed wait cycle is not a timeout
        $display("[TB] wait 64");
        extras[1] = 63; words[0] = 16'h0F0F;
        applyStimulus(1'b0, 'h60, 1, -1, -1);
        checkOutput("w64_done", dut_done_t, 73);
        checkOutput("w64_error", error, 1'b0);
        clear_env();

        // Reset in the middle of a four-word upload
        $display("[TB] mid reset");
        rel0 = release_cnt;
        for (int i = 0; i < 4; i++) words[i] = 16'($urandom);
        applyStimulus(1'b0, 'h400, 4, 8, -1);
        @(negedge clk);
        cur_t = 9;
        check_reset_vals("midrst");
        checkOutput("midrst_release", release_cnt - rel0, 0);
        reset_n = 1'b1;
        rdata_hold = 16'h0000;
        words[0] = 16'h5A5A;
        applyStimulus(1'b0, 'h410, 1, -1, -1);
        checkOutput("post_rst_ram", ram['h410], 16'h5A5A);

        // Randomized transfers
        $display("[TB] random");
        for (int it = 0; it < 30; it++) begin
            clear_env();
            d = int'($urandom_range(0, 1));
            n = int'($urandom_range(0, 6));
            base = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8188, 8191))
                                               : int'($urandom_range(0, 8191));
            for (int i = 0; i < 2 * n + 1; i++) begin
                extras[i] = int'($urandom_range(0, 3));
                if ($urandom_range(0, 40) == 0) extras[i] = 63;
                if ($urandom_range(0, 60) == 0) extras[i] = 500;
            end
            for (int t = 0; t < 200; t++) gate[t] = ($urandom_range(0, 4) != 0);
            for (int i = 0; i < 8; i++) words[i] = 16'($urandom);
            rel0 = release_cnt;
            applyStimulus(d[0], base, n, -1, 3);
            checkOutput("rnd_done_cnt", done_cnt, 1);
            checkOutput("rnd_release", release_cnt - rel0, timed_out ? 0 : 1);
            if (!d[0] && !timed_out) begin
                for (int k = 0; k < n; k++)
                    checkOutput("rnd_ram", ram[(base + k) % 8192], words[k]);
            end
            if (d[0] && !timed_out) begin
                nsent = rv_d.size();
                checkOutput("rnd_rv_n", nsent, n);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
